// File: rtl/gift_round_key_stage.sv
// gift_round_key_stage
// AddRoundKey stage for GIFT-64 / GIFT-128 that owns the key schedule and the
// round-constant LFSR. Each accepted state beat gets the current round key and
// constant, and the schedule then steps forward by one round.
//
// Handshake: a beat moves on a rising edge where inValid && outReady. The
// result is presented on outData while outValid is high. It is consumed on a
// rising edge where outValid && inDsReady. outReady depends only on internal
// state plus inKeyLoad and inDsReady, never on inValid.
module gift_round_key_stage #(
    parameter int BLOCK_WIDTH = 128,  // 64 (GIFT-64) or 128 (GIFT-128)
    parameter int NUM_ROUNDS  = 40    // 28 for GIFT-64, 40 for GIFT-128
) (
    input  logic                   inClk,
    input  logic                   inRstN,
    input  logic                   inKeyLoad,
    input  logic [127:0]           inKey,
    input  logic                   inValid,
    input  logic [BLOCK_WIDTH-1:0] inData,
    output logic                   outReady,
    output logic                   outValid,
    input  logic                   inDsReady,
    output logic [BLOCK_WIDTH-1:0] outData,
    output logic [5:0]             outRound,
    output logic                   outLast
);

    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS);

    // Key schedule and round bookkeeping
    logic [127:0]           key_q, key_d;
    logic [5:0]             const_q, const_d;
    logic [5:0]             round_q, round_d;
    logic                   armed_q, armed_d;

    // Output register
    logic                   valid_q, valid_d;
    logic [BLOCK_WIDTH-1:0] data_q, data_d;
    logic [5:0]             out_round_q, out_round_d;
    logic                   last_q, last_d;

    // Datapath intermediates
    logic                   accept;
    logic [5:0]             const_step;
    logic [5:0]             round_inc;
    logic [127:0]           key_step;
    logic [BLOCK_WIDTH-1:0] key_mix;
    logic [BLOCK_WIDTH-1:0] const_mix;
    logic [BLOCK_WIDTH-1:0] new_data;

    // Acceptance: a key load blocks the beat, and a held result must be leaving
    assign outReady = armed_q & ~inKeyLoad & (~valid_q | inDsReady);
    assign accept   = inValid & outReady;

    // The constant is stepped before use, so round 1 sees 0x01
    assign const_step = {const_q[4:0], const_q[5] ^ const_q[4] ^ 1'b1};
    assign round_inc  = round_q + 6'd1;

    // Next key: {k1>>>2, k0>>>12, k7..k2}, rotations on 16-bit words
    assign key_step = {key_q[17:16], key_q[31:18],
                       key_q[11:0],  key_q[15:12],
                       key_q[127:32]};

    // Round-key bit positions differ between the two block widths
    generate
        if (BLOCK_WIDTH == 128) begin : g_rk128
            // U = {k5,k4} lands on bit 4i+2, V = {k1,k0} on bit 4i+1
            always_comb begin
                key_mix = '0;
                for (int i = 0; i < 32; i++) begin
                    key_mix[4*i+2] = key_q[64+i];
                    key_mix[4*i+1] = key_q[i];
                end
            end
        end else begin : g_rk64
            // U = k1 lands on bit 4i+1, V = k0 on bit 4i
            always_comb begin
                key_mix = '0;
                for (int i = 0; i < 16; i++) begin
                    key_mix[4*i+1] = key_q[16+i];
                    key_mix[4*i]   = key_q[i];
                end
            end
        end
    endgenerate

    // Round constant c5..c0 on bits 23,19,15,11,7,3 plus the fixed top bit
    always_comb begin
        const_mix                = '0;
        const_mix[23]            = const_step[5];
        const_mix[19]            = const_step[4];
        const_mix[15]            = const_step[3];
        const_mix[11]            = const_step[2];
        const_mix[7]             = const_step[1];
        const_mix[3]             = const_step[0];
        const_mix[BLOCK_WIDTH-1] = 1'b1;
    end

    assign new_data = inData ^ key_mix ^ const_mix;

    // Next-state for schedule, round counter and output register
    always_comb begin
        key_d       = key_q;
        const_d     = const_q;
        round_d     = round_q;
        armed_d     = armed_q;
        valid_d     = valid_q;
        data_d      = data_q;
        out_round_d = out_round_q;
        last_d      = last_q;

        if (inKeyLoad) begin
            key_d   = inKey;
            const_d = '0;
            round_d = '0;
            armed_d = 1'b1;
        end else if (accept) begin
            key_d   = key_step;
            const_d = const_step;
            round_d = round_inc;
            if (round_inc == LAST_ROUND) begin
                armed_d = 1'b0;
            end
        end

        // A held beat survives a key load; it only leaves via inDsReady
        if (accept) begin
            valid_d     = 1'b1;
            data_d      = new_data;
            out_round_d = round_inc;
            last_d      = (round_inc == LAST_ROUND);
        end else if (inDsReady) begin
            valid_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            key_q       <= '0;
            const_q     <= '0;
            round_q     <= '0;
            armed_q     <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            out_round_q <= '0;
            last_q      <= 1'b0;
        end else begin
            key_q       <= key_d;
            const_q     <= const_d;
            round_q     <= round_d;
            armed_q     <= armed_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            out_round_q <= out_round_d;
            last_q      <= last_d;
        end
    end

    assign outValid = valid_q;
    assign outData  = data_q;
    assign outRound = out_round_q;
    assign outLast  = last_q;

endmodule

// File: tb/tb_gift_round_key_stage.sv
// Bench for gift_round_key_stage: a GIFT-128 and a GIFT-64 instance run in
// lockstep from shared stimulus, each checked against its own word-level model.
module tb_gift_round_key_stage;

  localparam int EW = 135;  // {last, round[5:0], data[127:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         in_key_load = 1'b0;
  logic [127:0] in_key = '0;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ds_ready = 1'b0;

  logic         out_ready_128, out_valid_128, out_last_128;
  logic [127:0] out_data_128;
  logic [5:0]   out_round_128;
  logic         out_ready_64, out_valid_64, out_last_64;
  logic [63:0]  out_data_64;
  logic [5:0]   out_round_64;

  gift_round_key_stage #(.BLOCK_WIDTH(128), .NUM_ROUNDS(40)) dut_128 (
    .inClk(clk), .inRstN(rst_n), .inKeyLoad(in_key_load), .inKey(in_key),
    .inValid(in_valid), .inData(in_data), .outReady(out_ready_128),
    .outValid(out_valid_128), .inDsReady(in_ds_ready), .outData(out_data_128),
    .outRound(out_round_128), .outLast(out_last_128)
  );

  gift_round_key_stage #(.BLOCK_WIDTH(64), .NUM_ROUNDS(28)) dut_64 (
    .inClk(clk), .inRstN(rst_n), .inKeyLoad(in_key_load), .inKey(in_key),
    .inValid(in_valid), .inData(in_data[63:0]), .outReady(out_ready_64),
    .outValid(out_valid_64), .inDsReady(in_ds_ready), .outData(out_data_64),
    .outRound(out_round_64), .outLast(out_last_64)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q0[$];  // GIFT-128 instance
  logic [EW-1:0] exp_q1[$];  // GIFT-64 instance

  // Published GIFT round-constant sequence
  logic [5:0] consts [0:39] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
    6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
    6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
    6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
  };

  logic [127:0] m_key [2];
  int           m_cnt [2];
  bit           m_armed [2];

  function automatic int nr_of(int d);
    return (d == 0) ? 40 : 28;
  endfunction

  function automatic int bw_of(int d);
    return (d == 0) ? 128 : 64;
  endfunction

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Word-level key schedule: {k1>>>2, k0>>>12, k7..k2}
  function automatic logic [127:0] key_next(input logic [127:0] k);
    logic [15:0] w0, w1;
    w0 = k[15:0];
    w1 = k[31:16];
    return {(w1 >> 2) | (w1 << 14), (w0 >> 12) | (w0 << 4), k[127:32]};
  endfunction

  function automatic logic [127:0] apply_rk(input int bw, input logic [127:0] k,
                                            input logic [5:0] c, input logic [127:0] d);
    logic [127:0] r;
    logic [31:0]  u, v;
    r = d;
    if (bw == 128) begin
      u = k[95:64];
      v = k[31:0];
      for (int i = 0; i < 32; i++) begin
        r[4*i+2] = r[4*i+2] ^ u[i];
        r[4*i+1] = r[4*i+1] ^ v[i];
      end
    end else begin
      u = {16'h0, k[31:16]};
      v = {16'h0, k[15:0]};
      for (int i = 0; i < 16; i++) begin
        r[4*i+1] = r[4*i+1] ^ u[i];
        r[4*i]   = r[4*i] ^ v[i];
      end
    end
    r[23] = r[23] ^ c[5];
    r[19] = r[19] ^ c[4];
    r[15] = r[15] ^ c[3];
    r[11] = r[11] ^ c[2];
    r[7]  = r[7] ^ c[1];
    r[3]  = r[3] ^ c[0];
    r[bw-1] = r[bw-1] ^ 1'b1;
    if (bw == 64) r[127:64] = '0;
    return r;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_key[d] = '0;
      m_cnt[d] = 0;
      m_armed[d] = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check_dut(input int d);
    logic          has;
    logic [EW-1:0] e;
    logic          a_valid, a_last;
    logic [127:0]  a_data;
    logic [5:0]    a_round;
    string         tag;
    tag     = (d == 0) ? "128" : "64";
    has     = (d == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
    a_valid = (d == 0) ? out_valid_128 : out_valid_64;
    a_last  = (d == 0) ? out_last_128 : out_last_64;
    a_data  = (d == 0) ? out_data_128 : {64'h0, out_data_64};
    a_round = (d == 0) ? out_round_128 : out_round_64;
    check({"out_valid_", tag}, 128'(a_valid), 128'(has));
    if (has) begin
      e = (d == 0) ? exp_q0[0] : exp_q1[0];
      check({"out_data_", tag}, a_data, e[127:0]);
      check({"out_round_", tag}, 128'(a_round), 128'(e[133:128]));
      check({"out_last_", tag}, 128'(a_last), 128'(e[134]));
    end
  endtask

  // One cycle: check held outputs, drive inputs, check outReady, update model.
  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic v, input logic ds, input logic [127:0] data, input logic kl);
    check_dut(0);
    check_dut(1);
    in_valid    = v;
    in_ds_ready = ds;
    in_data     = data;
    in_key_load = kl;
    #1;
    for (int d = 0; d < 2; d++) begin
      logic has, rdy, a_rdy;
      logic [127:0] r;
      has   = (d == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
      rdy   = m_armed[d] && !kl && (!has || ds);
      a_rdy = (d == 0) ? out_ready_128 : out_ready_64;
      check((d == 0) ? "out_ready_128" : "out_ready_64", 128'(a_rdy), 128'(rdy));
      if (ds && has) begin
        if (d == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
      end
      if (v && rdy) begin
        m_cnt[d]++;
        r = apply_rk(bw_of(d), m_key[d], consts[m_cnt[d]-1], data);
        if (d == 0) exp_q0.push_back({m_cnt[d] == nr_of(d), 6'(m_cnt[d]), r});
        else        exp_q1.push_back({m_cnt[d] == nr_of(d), 6'(m_cnt[d]), r});
        m_key[d] = key_next(m_key[d]);
        if (m_cnt[d] == nr_of(d)) m_armed[d] = 1'b0;
      end
      if (kl) begin
        m_key[d]   = in_key;
        m_cnt[d]   = 0;
        m_armed[d] = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_key(input logic [127:0] k);
    in_key = k;
    step(1'b0, 1'b1, '0, 1'b1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- known-answer table ----------------
  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
    logic [127:0] exp128;
    logic [63:0]  exp64;
  } vec_t;

  vec_t vecs [4];

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] k_saved, d_saved, held;

    vecs[0] = '{128'h0, 128'h0,
                128'h8000_0000_0000_0000_0000_0000_0000_0008, 64'h8000_0000_0000_0008};
    vecs[1] = '{{128{1'b1}}, 128'h0,
                128'hE666_6666_6666_6666_6666_6666_6666_666E, 64'hB333_3333_3333_333B};
    vecs[2] = '{128'h0, {128{1'b1}},
                128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF7, 64'h7FFF_FFFF_FFFF_FFF7};
    vecs[3] = '{{128{1'b1}}, {128{1'b1}},
                128'h1999_9999_9999_9999_9999_9999_9999_9991, 64'h4CCC_CCCC_CCCC_CCC4};

    model_reset();

    // Reset values
    #12;
    check("rst_valid_128", 128'(out_valid_128), 128'(0));
    check("rst_ready_128", 128'(out_ready_128), 128'(0));
    check("rst_data_128", out_data_128, 128'(0));
    check("rst_round_128", 128'(out_round_128), 128'(0));
    check("rst_last_128", 128'(out_last_128), 128'(0));
    check("rst_valid_64", 128'(out_valid_64), 128'(0));
    check("rst_data_64", 128'(out_data_64), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // No beat accepted before the first key load
    step(1'b1, 1'b1, rnd128(), 1'b0);

    // Known-answer vectors: round 1 after load
    for (int i = 0; i < 4; i++) begin
      load_key(vecs[i].key);
      step(1'b1, 1'b1, vecs[i].data, 1'b0);
      check("tbl_data_128", out_data_128, vecs[i].exp128);
      check("tbl_data_64", 128'(out_data_64), 128'(vecs[i].exp64));
      check("tbl_round_128", 128'(out_round_128), 128'(1));
      check("tbl_round_64", 128'(out_round_64), 128'(1));
    end

    // Full schedule, zero key / zero data: constant sequence, outLast, end of key
    load_key('0);
    for (int i = 0; i < 42; i++) begin
      step(1'b1, 1'b1, '0, 1'b0);
      if (i == 1) check("kat_round2_128", out_data_128,
                        128'h8000_0000_0000_0000_0000_0000_0000_0088);
    end
    check("after_last_ready_64", 128'(out_ready_64), 128'(0));

    // Backpressure with inValid held high
    load_key(rnd128());
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, rnd128(), 1'b0);
    held = out_data_128;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rnd128(), 1'b0);
    check("bp_hold_data_128", out_data_128, held);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, rnd128(), 1'b0);

    // Key load coincident with a valid beat: beat rejected, next one is round 1
    in_key = rnd128();
    step(1'b1, 1'b1, rnd128(), 1'b1);
    k_saved = in_key;
    d_saved = rnd128();
    step(1'b1, 1'b1, d_saved, 1'b0);
    check("kl_coinc_round_128", 128'(out_round_128), 128'(1));
    check("kl_coinc_data_128", out_data_128, apply_rk(128, k_saved, 6'h01, d_saved));

    // Reset pulse at round 10, then reload reproduces round 1
    k_saved = rnd128();
    d_saved = rnd128();
    load_key(k_saved);
    step(1'b1, 1'b1, d_saved, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, rnd128(), 1'b0);
    check_dut(0);
    check_dut(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_128", 128'(out_valid_128), 128'(0));
    check("midrst_data_128", out_data_128, 128'(0));
    check("midrst_round_128", 128'(out_round_128), 128'(0));
    check("midrst_ready_128", 128'(out_ready_128), 128'(0));
    check("midrst_valid_64", 128'(out_valid_64), 128'(0));
    check("midrst_round_64", 128'(out_round_64), 128'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, d_saved, 1'b0);
    load_key(k_saved);
    step(1'b1, 1'b1, d_saved, 1'b0);
    check("reload_r1_128", out_data_128, apply_rk(128, k_saved, 6'h01, d_saved));
    check("reload_r1_64", 128'(out_data_64), apply_rk(64, k_saved, 6'h01, d_saved));

    // Randomized traffic with occasional reloads
    for (int it = 0; it < 6; it++) begin
      load_key(rnd128());
      for (int c = 0; c < 100; c++) begin
        if ($urandom_range(0, 60) == 0) in_key = rnd128();
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rnd128(),
             $urandom_range(0, 60) == 0);
      end
    end

    // Drain
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    check_dut(0);
    check_dut(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
